// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// State encodings and requester IDs live here so the FSM and the picker agree.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        DMEM_ARB_IDLE  = 2'd0,
        DMEM_ARB_ISSUE = 2'd1,
        DMEM_ARB_WAIT  = 2'd2,
        DMEM_ARB_RESP  = 2'd3
    } dmem_arb_state_e;

    localparam logic DMEM_ARB_ID_M0 = 1'b0;
    localparam logic DMEM_ARB_ID_M1 = 1'b1;

    typedef struct packed {
        logic        id;
        logic [3:0]  ren;
        logic [3:0]  wen;
        logic [29:0] word_addr;
        logic [31:0] wdata;
    } dmem_arb_txn_t;

    // A request asking to read and write at once is malformed.
    function automatic logic dmem_arb_conflict(input dmem_arb_txn_t t);
        return (|t.ren) && (|t.wen);
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way winner select: round-robin on ties with DMEM_ARB_RR_EN, else m0 priority.
// Purely combinational; winner is only meaningful when req is nonzero.
module dmem_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner
);
    import dmem_arbiter_pkg::*;

`ifdef DMEM_ARB_RR_EN
    always_comb begin
        winner = DMEM_ARB_ID_M0;
        if (req == 2'b11) begin
            winner = ~last;
        end else if (!req[0] && req[1]) begin
            winner = DMEM_ARB_ID_M1;
        end
    end
`else
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        winner = DMEM_ARB_ID_M0;
        if (!req[0] && req[1]) begin
            winner = DMEM_ARB_ID_M1;
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-RAM arbiter, one transaction outstanding; optional round-robin
// tie-break under DMEM_ARB_RR_EN. gnt 1 cycle after req, write rsp 2 cycles after req.
module dmem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic        m0_req,
    input  logic [3:0]  m0_ren,
    input  logic [3:0]  m0_wen,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rsp_valid,
    output logic [31:0] m0_rsp_rdata,
    output logic        m0_rsp_err,

    input  logic        m1_req,
    input  logic [3:0]  m1_ren,
    input  logic [3:0]  m1_wen,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rsp_valid,
    output logic [31:0] m1_rsp_rdata,
    output logic        m1_rsp_err,

    output logic [3:0]  da_ren,
    output logic [3:0]  da_wen,
    output logic [31:0] da_addr,
    output logic [31:0] da_wdata,
    input  logic        da_rvalid,
    input  logic [31:0] da_rdata
);
    import dmem_arbiter_pkg::*;

    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW > 8) ? CNT_RAW : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    dmem_arb_state_e state, state_nxt;
    dmem_arb_txn_t   txn_q, txn_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [31:0]     rdata_q, rdata_nxt;
    logic            err_q, err_nxt;
    logic            winner;
    logic            pick_last;

    // Byte offset is dropped: the RAM is word-addressed.
    logic [3:0] unused_addr_lsb;
    assign unused_addr_lsb = {m0_addr[1:0], m1_addr[1:0]};

    dmem_rr_pick u_pick (
        .req    ({m1_req, m0_req}),
        .last   (pick_last),
        .winner (winner)
    );

`ifdef DMEM_ARB_RR_EN
    logic last_q;

    // Reset to m1 so m0 takes the first tie.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_q <= DMEM_ARB_ID_M1;
        end else if (state == DMEM_ARB_ISSUE) begin
            last_q <= txn_q.id;
        end
    end
    assign pick_last = last_q;
`else
    assign pick_last = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= DMEM_ARB_IDLE;
            txn_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            txn_q   <= txn_nxt;
            cnt_q   <= cnt_nxt;
            rdata_q <= rdata_nxt;
            err_q   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        txn_nxt   = txn_q;
        cnt_nxt   = cnt_q;
        rdata_nxt = rdata_q;
        err_nxt   = err_q;
        unique case (state)
            DMEM_ARB_IDLE: begin
                if (m0_req || m1_req) begin
                    txn_nxt.id = winner;
                    if (winner == DMEM_ARB_ID_M1) begin
                        txn_nxt.ren       = m1_ren;
                        txn_nxt.wen       = m1_wen;
                        txn_nxt.word_addr = m1_addr[31:2];
                        txn_nxt.wdata     = m1_wdata;
                    end else begin
                        txn_nxt.ren       = m0_ren;
                        txn_nxt.wen       = m0_wen;
                        txn_nxt.word_addr = m0_addr[31:2];
                        txn_nxt.wdata     = m0_wdata;
                    end
                    state_nxt = DMEM_ARB_ISSUE;
                end
            end
            DMEM_ARB_ISSUE: begin
                if (dmem_arb_conflict(txn_q)) begin
                    err_nxt   = 1'b1;
                    rdata_nxt = '0;
                    state_nxt = DMEM_ARB_RESP;
                end else if (|txn_q.ren) begin
                    cnt_nxt   = '0;
                    state_nxt = DMEM_ARB_WAIT;
                end else begin
                    err_nxt   = 1'b0;
                    rdata_nxt = '0;
                    state_nxt = DMEM_ARB_RESP;
                end
            end
            DMEM_ARB_WAIT: begin
                // Data arriving on the final cycle still wins over the timeout.
                if (da_rvalid) begin
                    err_nxt   = 1'b0;
                    rdata_nxt = da_rdata;
                    state_nxt = DMEM_ARB_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    err_nxt   = 1'b1;
                    rdata_nxt = '0;
                    state_nxt = DMEM_ARB_RESP;
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end
            DMEM_ARB_RESP: begin
                state_nxt = DMEM_ARB_IDLE;
            end
            default: begin
                state_nxt = DMEM_ARB_IDLE;
            end
        endcase
    end

    logic in_issue, in_resp, issue_ok;
    assign in_issue = (state == DMEM_ARB_ISSUE);
    assign in_resp  = (state == DMEM_ARB_RESP);
    assign issue_ok = in_issue && !dmem_arb_conflict(txn_q);

    assign da_ren   = issue_ok ? txn_q.ren : 4'h0;
    assign da_wen   = issue_ok ? txn_q.wen : 4'h0;
    assign da_addr  = {txn_q.word_addr, 2'b00};
    assign da_wdata = txn_q.wdata;

    assign m0_gnt = in_issue && (txn_q.id == DMEM_ARB_ID_M0);
    assign m1_gnt = in_issue && (txn_q.id == DMEM_ARB_ID_M1);

    assign m0_rsp_valid = in_resp && (txn_q.id == DMEM_ARB_ID_M0);
    assign m1_rsp_valid = in_resp && (txn_q.id == DMEM_ARB_ID_M1);
    assign m0_rsp_rdata = m0_rsp_valid ? rdata_q : 32'h0;
    assign m1_rsp_rdata = m1_rsp_valid ? rdata_q : 32'h0;
    assign m0_rsp_err   = m0_rsp_valid && err_q;
    assign m1_rsp_err   = m1_rsp_valid && err_q;

endmodule
